// File: rtl/lpgbt_uplink_link_ctrl.sv
// lpgbt_uplink_link_ctrl
// Link bring-up and supervision sequencer for the lpGBT-FPGA uplink receiver
// (clk40 domain). It sequences the MGT and uplink datapath resets, waits for
// uplink ready, qualifies stability, declares link-up and re-sequences on loss.
// Retry, loss and FEC-correction counters are exported for register readout.
//
// Optional feature macro: LPGBT_UPLINK_FEC_RESYNC_EN
//   When defined, an excessive FEC-correction rate while LINKED (FEC_THRESH
//   events inside a FEC_WINDOW-cycle fixed window) is treated as a link loss.
module lpgbt_uplink_link_ctrl #(
    parameter int MGT_RST_CYCLES = 64,
    parameter int UPL_RST_CYCLES = 32,
    parameter int RDY_TIMEOUT    = 40000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 8,
    parameter int TIMER_W        = 16
`ifdef LPGBT_UPLINK_FEC_RESYNC_EN
    ,
    parameter int FEC_WINDOW     = 4096,
    parameter int FEC_THRESH     = 16
`endif
) (
    input  logic        clk40_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        resync_i,
    input  logic        clr_cnt_i,
    input  logic        uplinkrdy_i,
    input  logic        uplinkFEC_i,
    output logic        mgt_rst_o,
    output logic        uplink_rst_o,
    output logic        link_up_o,
    output logic        fault_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retry_cnt_o,
    output logic [7:0]  loss_cnt_o,
    output logic [15:0] fec_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MGT_RST    = 3'd1,
        S_UPL_RST    = 3'd2,
        S_WAIT_RDY   = 3'd3,
        S_STABLE_CHK = 3'd4,
        S_LINKED     = 3'd5,
        S_FAULT      = 3'd6
    } state_t;

    // Last timer value of each timed state (timer starts at 0 on entry).
    localparam logic [TIMER_W-1:0] L_MGT_LAST    = TIMER_W'(MGT_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] L_UPL_LAST    = TIMER_W'(UPL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] L_RDY_LAST    = TIMER_W'(RDY_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] L_STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]         L_MAX_RETRY   = 8'(MAX_RETRIES);

    state_t               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic [7:0]           r_retry;
    logic [7:0]           r_loss;
    logic [15:0]          r_fec;
    logic                 r_mgt_rst;
    logic                 r_upl_rst;
    logic                 r_link_up;
    logic                 r_fault;

    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [7:0]           w_retry_nxt;
    logic [7:0]           w_retry_inc;
    logic                 w_retry_evt;
    logic                 w_loss_evt;
    logic                 w_fec_trip;
    logic                 w_fec_linked;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_retry_inc  = sat_inc8(r_retry);
    assign w_fec_linked = (r_state == S_LINKED) && uplinkFEC_i;

`ifdef LPGBT_UPLINK_FEC_RESYNC_EN
    localparam int WIN_TW = $clog2(FEC_WINDOW + 1);
    localparam int WIN_CW = $clog2(FEC_THRESH + 1);
    localparam logic [WIN_TW-1:0] L_WIN_LAST  = WIN_TW'(FEC_WINDOW - 1);
    localparam logic [WIN_CW-1:0] L_THRESH_M1 = WIN_CW'(FEC_THRESH - 1);

    logic [WIN_TW-1:0] r_win_timer;
    logic [WIN_CW-1:0] r_win_cnt;

    // The event that brings the in-window count up to the threshold trips.
    assign w_fec_trip = w_fec_linked && (r_win_cnt == L_THRESH_M1);

    // Fixed FEC window: held cleared outside LINKED, restarts on each expiry.
    always_ff @(posedge clk40_i or posedge rst_i) begin
        if (rst_i) begin
            r_win_timer <= '0;
            r_win_cnt   <= '0;
        end else if (r_state != S_LINKED || w_state_nxt != S_LINKED) begin
            r_win_timer <= '0;
            r_win_cnt   <= '0;
        end else if (r_win_timer == L_WIN_LAST) begin
            r_win_timer <= '0;
            r_win_cnt   <= '0;
        end else begin
            r_win_timer <= r_win_timer + WIN_TW'(1);
            if (uplinkFEC_i) begin
                r_win_cnt <= r_win_cnt + WIN_CW'(1);
            end
        end
    end
`else
    assign w_fec_trip = 1'b0;
`endif

    // Next-state, timer and retry-count logic with override priority.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_retry_evt = 1'b0;
        w_loss_evt  = 1'b0;
        w_timer_nxt = r_timer;

        if (!enable_i) begin
            w_state_nxt = S_IDLE;
            w_retry_nxt = 8'd0;
        end else if (resync_i && (r_state inside {S_WAIT_RDY, S_STABLE_CHK,
                                                  S_LINKED, S_FAULT})) begin
            w_state_nxt = S_MGT_RST;
            w_retry_nxt = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_MGT_RST;
                end
                S_MGT_RST: begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                    if (r_timer == L_MGT_LAST) begin
                        w_state_nxt = S_UPL_RST;
                    end
                end
                S_UPL_RST: begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                    if (r_timer == L_UPL_LAST) begin
                        w_state_nxt = S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                    if (uplinkrdy_i) begin
                        w_state_nxt = S_STABLE_CHK;
                    end else if (r_timer == L_RDY_LAST) begin
                        w_retry_evt = 1'b1;
                    end
                end
                S_STABLE_CHK: begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                    if (!uplinkrdy_i) begin
                        w_retry_evt = 1'b1;
                    end else if (r_timer == L_STABLE_LAST) begin
                        w_state_nxt = S_LINKED;
                    end
                end
                S_LINKED: begin
                    if (!uplinkrdy_i || w_fec_trip) begin
                        w_loss_evt  = 1'b1;
                        w_retry_nxt = 8'd0;
                        w_state_nxt = S_MGT_RST;
                    end
                end
                S_FAULT: begin
                    w_state_nxt = S_FAULT;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase

            if (w_retry_evt) begin
                w_retry_nxt = w_retry_inc;
                w_state_nxt = (w_retry_inc >= L_MAX_RETRY) ? S_FAULT : S_MGT_RST;
            end
        end

        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end
    end

    // State, timer, retry count and registered per-state outputs.
    always_ff @(posedge clk40_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_retry   <= 8'd0;
            r_mgt_rst <= 1'b1;
            r_upl_rst <= 1'b1;
            r_link_up <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_retry   <= w_retry_nxt;
            r_mgt_rst <= (w_state_nxt inside {S_IDLE, S_MGT_RST, S_FAULT});
            r_upl_rst <= (w_state_nxt inside {S_IDLE, S_MGT_RST, S_UPL_RST, S_FAULT});
            r_link_up <= (w_state_nxt == S_LINKED);
            r_fault   <= (w_state_nxt == S_FAULT);
        end
    end

    // Loss and FEC counters; a coincident clear beats any increment.
    always_ff @(posedge clk40_i or posedge rst_i) begin
        if (rst_i) begin
            r_loss <= 8'd0;
            r_fec  <= 16'd0;
        end else if (clr_cnt_i) begin
            r_loss <= 8'd0;
            r_fec  <= 16'd0;
        end else begin
            if (w_loss_evt) begin
                r_loss <= sat_inc8(r_loss);
            end
            if (w_fec_linked) begin
                r_fec <= sat_inc16(r_fec);
            end
        end
    end

    assign mgt_rst_o    = r_mgt_rst;
    assign uplink_rst_o = r_upl_rst;
    assign link_up_o    = r_link_up;
    assign fault_o      = r_fault;
    assign state_o      = r_state;
    assign retry_cnt_o  = r_retry;
    assign loss_cnt_o   = r_loss;
    assign fec_cnt_o    = r_fec;

endmodule

// File: tb/tb_lpgbt_uplink_link_ctrl.sv
// Directed bench for lpgbt_uplink_link_ctrl with reduced timing parameters:
// MGT_RST_CYCLES=4, UPL_RST_CYCLES=2, RDY_TIMEOUT=20, STABLE_CYCLES=8,
// MAX_RETRIES=3. Inputs change and outputs are sampled 1 ns after posedge.
module tb_lpgbt_uplink_link_ctrl;

    logic        clk40;
    logic        rst;
    logic        enable;
    logic        resync;
    logic        clr_cnt;
    logic        rdy;
    logic        fec;
    logic        mgt_rst;
    logic        upl_rst;
    logic        link_up;
    logic        fault;
    logic [2:0]  state;
    logic [7:0]  retry_cnt;
    logic [7:0]  loss_cnt;
    logic [15:0] fec_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    lpgbt_uplink_link_ctrl #(
        .MGT_RST_CYCLES(4),
        .UPL_RST_CYCLES(2),
        .RDY_TIMEOUT   (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .TIMER_W       (16)
    ) dut (
        .clk40_i     (clk40),
        .rst_i       (rst),
        .enable_i    (enable),
        .resync_i    (resync),
        .clr_cnt_i   (clr_cnt),
        .uplinkrdy_i (rdy),
        .uplinkFEC_i (fec),
        .mgt_rst_o   (mgt_rst),
        .uplink_rst_o(upl_rst),
        .link_up_o   (link_up),
        .fault_o     (fault),
        .state_o     (state),
        .retry_cnt_o (retry_cnt),
        .loss_cnt_o  (loss_cnt),
        .fec_cnt_o   (fec_cnt)
    );

    initial clk40 = 1'b0;
    always #5 clk40 = ~clk40;

    task automatic step(input int n);
        repeat (n) @(posedge clk40);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; resync = 1'b0; clr_cnt = 1'b0;
        rdy = 1'b0; fec = 1'b0;
        step(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mgt", 32'(mgt_rst), 32'd1);
        chk("rst_upl", 32'(upl_rst), 32'd1);
        chk("rst_link", 32'(link_up), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_counts", {retry_cnt, loss_cnt, fec_cnt}, 32'd0);

        // Nominal bring-up: cycle 0 here, rdy sampled high from edge 10
        rst = 1'b0; enable = 1'b1;
        step(4);                                   // edge 4
        chk("nom_e4_state", 32'(state), 32'd1);
        chk("nom_e4_mgt", 32'(mgt_rst), 32'd1);
        step(1);                                   // edge 5
        chk("nom_e5_state", 32'(state), 32'd2);
        chk("nom_e5_mgt", 32'(mgt_rst), 32'd0);
        chk("nom_e5_upl", 32'(upl_rst), 32'd1);
        step(1);                                   // edge 6
        chk("nom_e6_upl", 32'(upl_rst), 32'd1);
        step(1);                                   // edge 7
        chk("nom_e7_state", 32'(state), 32'd3);
        chk("nom_e7_upl", 32'(upl_rst), 32'd0);
        step(2);                                   // edge 9
        rdy = 1'b1;
        step(1);                                   // edge 10
        chk("nom_e10_state", 32'(state), 32'd4);
        step(7);                                   // edge 17
        chk("nom_e17_link", 32'(link_up), 32'd0);
        step(1);                                   // edge 18
        chk("nom_e18_link", 32'(link_up), 32'd1);
        chk("nom_e18_state", 32'(state), 32'd5);
        chk("nom_retry", 32'(retry_cnt), 32'd0);

        // FEC counting in LINKED
        fec = 1'b1;
        step(10);
        fec = 1'b0;
        chk("fec_linked10", 32'(fec_cnt), 32'd10);

        // Loss in LINKED, then park in WAIT_RDY with FEC pulses
        rdy = 1'b0;
        step(1);                                   // loss edge E
        chk("loss_link", 32'(link_up), 32'd0);
        chk("loss_state", 32'(state), 32'd1);
        chk("loss_cnt1", 32'(loss_cnt), 32'd1);
        chk("loss_retry", 32'(retry_cnt), 32'd0);
        step(6);                                   // E+6
        chk("wait_state", 32'(state), 32'd3);
        fec = 1'b1;
        step(5);                                   // E+11
        fec = 1'b0;
        chk("fec_wait", 32'(fec_cnt), 32'd10);
        chk("wait_state2", 32'(state), 32'd3);
        rdy = 1'b1;
        step(1);                                   // E+12
        chk("stable_state", 32'(state), 32'd4);
        step(8);                                   // E+20
        chk("relink", 32'(link_up), 32'd1);

        // Clear coincident with an FEC pulse
        fec = 1'b1; clr_cnt = 1'b1;
        step(1);
        fec = 1'b0; clr_cnt = 1'b0;
        chk("clr_fec", 32'(fec_cnt), 32'd0);
        chk("clr_loss", 32'(loss_cnt), 32'd0);

        // 300 loss/relink cycles, loss count saturates at 255
        for (int i = 0; i < 300; i++) begin
            rdy = 1'b0;
            step(1);
            rdy = 1'b1;
            step(15);
            chk("loop_relink", 32'(link_up), 32'd1);
        end
        chk("loss_sat", 32'(loss_cnt), 32'd255);

        // Stability glitch: 5 high, 1 low, high again
        rdy = 1'b0;
        step(1);                                   // E
        chk("loss_sat_hold", 32'(loss_cnt), 32'd255);
        rdy = 1'b1;
        step(11);                                  // E+11
        chk("glitch_stable", 32'(state), 32'd4);
        rdy = 1'b0;
        step(1);                                   // E+12
        chk("glitch_state", 32'(state), 32'd1);
        chk("glitch_retry", 32'(retry_cnt), 32'd1);
        rdy = 1'b1;
        step(14);                                  // E+26
        chk("glitch_chk2", 32'(state), 32'd4);
        step(1);                                   // E+27
        chk("glitch_link2", 32'(link_up), 32'd1);

        // Timeout to fault: resync from LINKED with rdy held low
        rdy = 1'b0; resync = 1'b1;
        step(1);                                   // R
        resync = 1'b0;
        chk("resync_retry0", 32'(retry_cnt), 32'd0);
        step(25);                                  // R+25
        chk("to1_wait", 32'(state), 32'd3);
        step(1);                                   // R+26
        chk("to1_state", 32'(state), 32'd1);
        chk("to1_retry", 32'(retry_cnt), 32'd1);
        step(26);                                  // R+52
        chk("to2_retry", 32'(retry_cnt), 32'd2);
        step(26);                                  // R+78
        chk("to3_retry", 32'(retry_cnt), 32'd3);
        chk("fault_state", 32'(state), 32'd6);
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_resets", {30'd0, mgt_rst, upl_rst}, 32'd3);
        step(5);
        chk("fault_hold", 32'(state), 32'd6);
        resync = 1'b1;
        step(1);
        resync = 1'b0;
        chk("fault_resync_state", 32'(state), 32'd1);
        chk("fault_resync_retry", 32'(retry_cnt), 32'd0);
        chk("fault_resync_flag", 32'(fault), 32'd0);

        // enable_i low mid-STABLE_CHK
        rdy = 1'b1;
        step(10);
        chk("ovr_stable", 32'(state), 32'd4);
        enable = 1'b0;
        step(1);
        chk("ovr_idle", 32'(state), 32'd0);
        chk("ovr_resets", {30'd0, mgt_rst, upl_rst}, 32'd3);

        // Asynchronous reset mid-UPL_RST
        enable = 1'b1;
        step(5);
        chk("arst_upl", 32'(state), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_resets", {30'd0, mgt_rst, upl_rst}, 32'd3);
        chk("arst_flags", {30'd0, link_up, fault}, 32'd0);
        chk("arst_loss", 32'(loss_cnt), 32'd0);
        step(1);
        rst = 1'b0;

`ifdef LPGBT_UPLINK_FEC_RESYNC_EN
        // FEC-rate resync: 16 pulses inside the window count as a loss
        rdy = 1'b1;
        step(16);
        chk("fw_link", 32'(link_up), 32'd1);
        fec = 1'b1;
        step(15);
        chk("fw_15", 32'(state), 32'd5);
        step(1);
        fec = 1'b0;
        chk("fw_trip", 32'(state), 32'd1);
        chk("fw_loss", 32'(loss_cnt), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
